mem_boot_loader: RTL

- Sits between the multicycle Processor and Memory; at bring-up it owns the Memory write port.
- Streams program and data words from a host valid/ready channel into Memory, holding the Processor in reset throughout.
- After loading, keeps the Processor in reset for a fixed number of cycles, then releases it and passes the Processor's memory bus straight through.
- Replaces bulk parallel preloading with a cycle-accurate, synthesizable load path.

---
 rtl/mem_boot_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_boot_loader.sv
// mem_boot_loader
// ---------------
// Boot-time loader between the multicycle Processor and its Memory. After a
// start pulse it streams an instruction segment and then a data segment from
// a host valid/ready channel straight into the Memory write port, holding the
// Processor in reset. Once loading completes it keeps cpu_rst high for
// HOLD_CYCLES cycles, then releases the Processor and passes its memory bus
// through unchanged.
//
// Optional feature (macro BOOT_CHECKSUM_EN): a 32-bit running sum of every
// loaded word is compared with one extra host beat after the last segment;
// a mismatch parks the loader in ERROR with err=1 and the Processor in reset.
// Without the macro there is no CHECK state and err is tied to 0.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             one-cycle pulse; honoured in IDLE, RUN and ERROR only
//   in_valid/in_ready host word handshake, in_data = host word
//   proc_*            Processor memory bus (used only in RUN)
//   mem_*             Memory bus (loader writes while loading, pass-through in RUN)
//   cpu_rst           Processor reset, low only in RUN
//   busy              high in LOAD_INST, LOAD_DATA, CHECK and HOLD
//   done              high in RUN
//   err               checksum mismatch, sticky until rst or start

module mem_boot_loader #(
  parameter int unsigned INST_BASE   = 0,
  parameter int unsigned INST_WORDS  = 14,
  parameter int unsigned DATA_BASE   = 1000,
  parameter int unsigned DATA_WORDS  = 10,
  parameter int unsigned DEPTH       = 2048,
  parameter int unsigned ADDR_SHIFT  = 2,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        proc_mem_write,
  input  logic        proc_mem_read,
  input  logic [31:0] proc_mem_addr,
  input  logic [31:0] proc_write_data,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Word indices are kept already reduced modulo DEPTH, so the segment start
  // is folded here and the per-beat step is a compare-and-wrap increment.
  localparam logic [IDX_W-1:0] INST_START = IDX_W'(INST_BASE % DEPTH);
  localparam logic [IDX_W-1:0] DATA_START = IDX_W'(DATA_BASE % DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [31:0]      INST_LAST  = 32'(INST_WORDS - 1);
  localparam logic [31:0]      DATA_LAST  = 32'(DATA_WORDS - 1);
  localparam logic [7:0]       HOLD_LAST  = 8'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_INST, LOAD_DATA, CHECK, HOLD, RUN, ERROR
  } state_t;

  // State entered once every segment word has been written.
  localparam state_t POST_LOAD =
`ifdef BOOT_CHECKSUM_EN
    CHECK;
`else
    HOLD;
`endif

  // Empty segments are skipped entirely.
  localparam state_t AFTER_INST  = (DATA_WORDS != 0) ? LOAD_DATA : POST_LOAD;
  localparam state_t FIRST_STATE = (INST_WORDS != 0) ? LOAD_INST : AFTER_INST;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      cnt;
  logic [IDX_W-1:0] idx;
  logic [7:0]       hold_cnt;
  logic             accept;
  logic             loading;

`ifdef BOOT_CHECKSUM_EN
  logic [31:0]      sum;
  logic             restart;

  assign restart = start && (state == IDLE || state == RUN || state == ERROR);
`endif

  assign accept  = in_valid && in_ready;
  assign loading = (state == LOAD_INST) || (state == LOAD_DATA);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN, ERROR: if (start) state_nxt = FIRST_STATE;
      LOAD_INST:        if (accept && cnt == INST_LAST) state_nxt = AFTER_INST;
      LOAD_DATA:        if (accept && cnt == DATA_LAST) state_nxt = POST_LOAD;
`ifdef BOOT_CHECKSUM_EN
      // The checksum beat is consumed but never written to memory.
      CHECK:            if (accept) state_nxt = (in_data == sum) ? HOLD : ERROR;
`endif
      HOLD:             if (hold_cnt == HOLD_LAST) state_nxt = RUN;
      default:          state_nxt = IDLE;
    endcase
  end

  // State, counters and the state-derived outputs all update together, so
  // in_ready/cpu_rst/busy/done/err are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      hold_cnt <= '0;
      cpu_rst  <= 1'b1;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum      <= '0;
      err      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      if (state_nxt != state)
        cnt <= '0;
      else if (loading && accept)
        cnt <= cnt + 32'd1;

      // Segment entry overrides the per-beat increment on the boundary beat.
      if (loading && accept)
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (state_nxt == LOAD_INST && state != LOAD_INST)
        idx <= INST_START;
      if (state_nxt == LOAD_DATA && state != LOAD_DATA)
        idx <= DATA_START;

      hold_cnt <= (state == HOLD && state_nxt == HOLD) ? hold_cnt + 8'd1 : 8'd0;

      in_ready <= (state_nxt == LOAD_INST) || (state_nxt == LOAD_DATA) ||
                  (state_nxt == CHECK);
      cpu_rst  <= (state_nxt != RUN);
      busy     <= (state_nxt == LOAD_INST) || (state_nxt == LOAD_DATA) ||
                  (state_nxt == CHECK) || (state_nxt == HOLD);
      done     <= (state_nxt == RUN);
`ifdef BOOT_CHECKSUM_EN
      if (restart)
        sum <= '0;
      else if (loading && accept)
        sum <= sum + in_data;
      err <= (state_nxt == ERROR);
`endif
    end
  end

`ifndef BOOT_CHECKSUM_EN
  assign err = 1'b0;
`endif

  // Memory bus is combinational: loader writes land in the accepting cycle,
  // and the Processor sees Memory with no added latency once running.
  always_comb begin
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (state)
      LOAD_INST, LOAD_DATA: begin
        mem_write      = accept;
        mem_addr       = 32'(idx) << ADDR_SHIFT;
        mem_write_data = accept ? in_data : 32'd0;
      end
      RUN: begin
        mem_write      = proc_mem_write;
        mem_read       = proc_mem_read;
        mem_addr       = proc_mem_addr;
        mem_write_data = proc_write_data;
      end
      default: ;
    endcase
  end

endmodule
